// File: rtl/snail_pattern_tx.sv
// Serial pattern transmitter: buffers parallel words in a small FIFO and shifts them out MSB-first.
// It also produces a reference 1101/1110 match strobe and a saturating match count for detector benches.
module snail_pattern_tx #(
    parameter int   WORD_W     = 4,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              enable,
    output logic              A,
    output logic              a_valid,
    output logic              word_done,
    output logic              busy,
    output logic              expect_y,
    output logic [7:0]        match_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ---------------- input FIFO ----------------
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;

    assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];

    // Storage needs no reset: the pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // ---------------- shift FSM ----------------
    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_q, a_d;
    logic              a_valid_q, a_valid_d;
    logic              word_done_q, word_done_d;
    logic              start_word;

    assign start_word = enable && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        a_valid_d   = a_valid_q;
        word_done_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_word) begin
                    pop       = 1'b1;
                    a_d       = head[WORD_W-1];
                    a_valid_d = 1'b1;
                    shreg_d   = head << 1;
                    cnt_d     = CNT_W'(WORD_W - 1);
                    state_d   = ST_SHIFT;
                end else begin
                    a_d       = IDLE_BIT;
                    a_valid_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q > CNT_W'(1)) begin
                    a_d     = shreg_q[WORD_W-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else if (cnt_q == CNT_W'(1)) begin
                    a_d         = shreg_q[WORD_W-1];
                    shreg_d     = shreg_q << 1;
                    cnt_d       = '0;
                    word_done_d = 1'b1;
                end else if (start_word) begin
                    // Last bit is on A now; chain the next word with no idle cycle.
                    pop       = 1'b1;
                    a_d       = head[WORD_W-1];
                    a_valid_d = 1'b1;
                    shreg_d   = head << 1;
                    cnt_d     = CNT_W'(WORD_W - 1);
                end else begin
                    a_d       = IDLE_BIT;
                    a_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                a_d       = IDLE_BIT;
                a_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            a_q         <= IDLE_BIT;
            a_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            a_valid_q   <= a_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign A         = a_q;
    assign a_valid   = a_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q == ST_SHIFT) || !fifo_empty;

    // ---------------- golden detector model ----------------
    // Idle bits are part of the observed stream, so history shifts every cycle.
    logic [2:0] hist_q, hist_d;
    logic [7:0] match_cnt_q, match_cnt_d;

    assign expect_y = ({hist_q, a_q} == 4'b1101) || ({hist_q, a_q} == 4'b1110);

    always_comb begin
        hist_d      = {hist_q[1:0], a_q};
        match_cnt_d = match_cnt_q;
        if (expect_y && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q      <= 3'b000;
            match_cnt_q <= 8'd0;
        end else begin
            hist_q      <= hist_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_snail_pattern_tx.sv
// Bench for snail_pattern_tx: directed scenarios plus random traffic, checked against a queue-based
// stream model; accepted words feed a bit scoreboard that is drained whenever the DUT shows a_valid.
module tb_snail_pattern_tx;

    localparam int   W        = 4;
    localparam int   DEPTH    = 4;
    localparam logic IDLE_BIT = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         enable;
    logic         A;
    logic         a_valid;
    logic         word_done;
    logic         busy;
    logic         expect_y;
    logic [7:0]   match_cnt;

    snail_pattern_tx #(
        .WORD_W    (W),
        .FIFO_DEPTH(DEPTH),
        .IDLE_BIT  (IDLE_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .enable   (enable),
        .A        (A),
        .a_valid  (a_valid),
        .word_done(word_done),
        .busy     (busy),
        .expect_y (expect_y),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit b;
        bit last;
    } sb_t;

    bit [W-1:0] fifo_q[$];   // words waiting in the FIFO
    bit         pend_q[$];   // bits of the current word not yet on A
    bit         stream_q[$]; // last four values of A, newest at the back
    sb_t        sb_q[$];     // every payload bit the DUT still owes us
    bit         m_a;
    bit         m_av;
    int         m_cnt;

    function automatic bit m_window_hit();
        bit [3:0] win;
        win = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
        return (win == 4'b1101) || (win == 4'b1110);
    endfunction

    task automatic model_reset();
        fifo_q.delete();
        pend_q.delete();
        sb_q.delete();
        stream_q = '{1'b0, 1'b0, 1'b0, IDLE_BIT};
        m_a   = IDLE_BIT;
        m_av  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit [W-1:0] d, input bit en);
        int         pre_size;
        bit [W-1:0] w;
        pre_size = fifo_q.size();
        if (m_window_hit() && m_cnt < 255) m_cnt++;
        if (pend_q.size() > 0) begin
            m_a  = pend_q.pop_front();
            m_av = 1'b1;
        end else if (en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            for (int i = W - 2; i >= 0; i--) pend_q.push_back(w[i]);
            m_a  = w[W-1];
            m_av = 1'b1;
        end else begin
            m_a  = IDLE_BIT;
            m_av = 1'b0;
        end
        // Acceptance depends on occupancy before this edge; a fresh word cannot be popped this edge.
        if (v && pre_size < DEPTH) begin
            fifo_q.push_back(d);
            for (int i = W - 1; i >= 0; i--) sb_q.push_back('{b: d[i], last: (i == 0)});
        end
        stream_q.push_back(m_a);
        while (stream_q.size() > 4) void'(stream_q.pop_front());
    endtask

    // ---------------- monitor ----------------
    always begin
        sb_t e;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(in_valid, in_data, enable);
        #1;
        check("a_valid", 32'(a_valid), 32'(m_av));
        if (a_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_bit", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("A_bit", 32'(A), 32'(e.b));
                check("word_done", 32'(word_done), 32'(e.last));
            end
        end else begin
            check("A_idle", 32'(A), 32'(IDLE_BIT));
            check("word_done_idle", 32'(word_done), 32'd0);
        end
        check("expect_y", 32'(expect_y), 32'(m_window_hit()));
        check("match_cnt", 32'(match_cnt), 32'(m_cnt));
        check("in_ready", 32'(in_ready), 32'(fifo_q.size() < DEPTH));
        check("busy", 32'(busy), 32'(m_av || (fifo_q.size() > 0)));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit en);
        in_valid = v;
        in_data  = d;
        enable   = en;
        @(negedge clk);
        $display("cycle t=%0t in_valid=%0b in_data=%h enable=%0b -> A=%0b a_valid=%0b word_done=%0b expect_y=%0b match_cnt=%0d",
                 $time, v, d, en, A, a_valid, word_done, expect_y, match_cnt);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, en);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("rst_A", 32'(A), 32'(IDLE_BIT));
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_expect_y", 32'(expect_y), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int accepted;
        int guard;
        bit rdy;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        enable   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single word 1101.
        cyc(1'b1, 4'hD, 1'b1);
        idle(8, 1'b1);

        // Back-to-back 1110, 1101.
        cyc(1'b1, 4'hE, 1'b1);
        cyc(1'b1, 4'hD, 1'b1);
        idle(12, 1'b1);

        // Fill with enable low; the fifth word must be dropped.
        cyc(1'b1, 4'hF, 1'b0);
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'hD, 1'b0);
        cyc(1'b1, 4'hE, 1'b0);
        cyc(1'b1, 4'h1, 1'b0);
        idle(22, 1'b1);

        // Enable dropped mid-word: word finishes, next stays queued.
        cyc(1'b1, 4'hB, 1'b1);
        cyc(1'b1, 4'h6, 1'b1);
        idle(8, 1'b0);
        idle(8, 1'b1);

        // Reset on the third bit of 1101.
        cyc(1'b1, 4'hD, 1'b1);
        idle(3, 1'b1);
        do_reset(2);
        idle(4, 1'b1);

        // 300 words of 1101 streamed continuously; count saturates.
        accepted = 0;
        guard    = 0;
        while (accepted < 300 && guard < 3000) begin
            rdy = in_ready;
            cyc(1'b1, 4'hD, 1'b1);
            if (rdy) accepted++;
            guard++;
        end
        if (accepted < 300) check("stream_accept_budget", 32'(accepted), 32'd300);
        idle(24, 1'b1);
        check("match_cnt_saturated", 32'(match_cnt), 32'd255);

        // Random traffic from a clean start.
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(30, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
